ami_channel_app_arbiter: RTL and testbench
==========================================

# ami_channel_app_arbiter

Per-channel arbiter that sits directly downstream of the per-app channel merge stage. It takes one merged AMIReq stream from each app mapped to a memory channel, picks one per cycle round-robin, and registers it toward the channel's memory controller port. Each app has an outstanding-read cap, so one app cannot monopolise read-return bandwidth on the channel.

## Interface
Parameters:
- NUM_APPS, 4: number of app request streams; power of two, 1..8.
- MAX_OUTSTANDING, 16: maximum in-flight reads per app; 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1): derived width of the outstanding counter.

Ports:
- clk  in  1  user clock.
- rst  in  1  asynchronous, active-high reset.
- app_req_in[NUM_APPS]  in  AMIReq  merged request per app; valid means pending.
- app_req_grant_out[NUM_APPS]  out  1  same-cycle accept; the app dequeues on this.
- mem_req_out  out  AMIReq  registered request to the memory channel.
- mem_req_grant_in  in  1  memory accepts mem_req_out this cycle.
- rsp_valid_in  in  1  read response returned on this channel.
- rsp_app_in  in  AMI_APP_BITS  srcApp of the returned response.
- cnt_underflow_out  out  1  sticky; set when a response arrives for an app whose counter is 0.
- stat_grants_out[NUM_APPS]  out  32  per-app grant count; see Configuration.

## Operation
- Holding register (HR): one AMIReq entry. mem_req_out = HR, so mem_req_out.valid = HR.valid.
- can_accept = !HR.valid || mem_req_grant_in.
- Eligible app i:
  - app_req_in[i].valid, and
  - app_req_in[i].isWrite, or outst[i] < MAX_OUTSTANDING.
- Arbitration: round-robin over eligible apps, starting from pointer ptr. The winner is gated by can_accept.
  - At most one app_req_grant_out is high per cycle.
  - Grant is combinational, in the same cycle the request is presented.
- On a grant to app k:
  - HR <= app_req_in[k].
  - HR.srcApp is overwritten with k.
  - ptr <= (k+1) mod NUM_APPS.
- No grant and mem_req_grant_in: HR.valid <= 0.
- No grant and !mem_req_grant_in: HR holds. Its contents must stay stable while valid and not granted.
- outst[i] increments on a granted read from app i and decrements on rsp_valid_in with rsp_app_in==i.
  - Both in the same cycle: no change.
  - Decrement at 0: counter stays 0 and cnt_underflow_out sets. Only reset clears it.
  - rsp_app_in >= NUM_APPS: ignored, and the underflow flag is not set.
- Writes never touch outst.
- Reset values: HR.valid 0, all grants 0, all outst 0, ptr 0, cnt_underflow_out 0, stat counters 0.
- Reset mid-operation discards HR and all counts. The system must drain responses before reset.

## Timing
- Latency: a request granted in cycle N appears on mem_req_out in cycle N+1.
- Throughput: one request per cycle per channel while mem_req_grant_in stays high.
- mem_req_grant_in is sampled only when HR.valid. A grant while !HR.valid is ignored.
- Back-pressure: while HR.valid && !mem_req_grant_in, all app_req_grant_out are 0.
- An app at the cap is skipped without a stall. Its reads become eligible again in the cycle after the decrement registers.

## Configuration
- AMI_CHAN_ARB_STATS_EN defined:
  - stat_grants_out[i] counts grants to app i.
  - 32 bits, saturating at 0xFFFFFFFF, reset to 0.
- Undefined:
  - no counters are instantiated.
  - stat_grants_out is tied to 0; the port list is unchanged.

## Structure
- AMITypes holds:
  - AMIReq.
  - AMI_APP_BITS.
  - Default constants AMI_CHAN_ARB_MAX_OUTSTANDING and AMI_CHAN_ARB_NUM_APPS.
- One sub-module, ami_outst_counter: one per app, holding CNT_W-bit inc/dec/saturate-at-zero logic with an underflow pulse.
- Round-robin selection uses the team's existing RRWCArbiter, with the request vector masked by eligibility and can_accept.

## Test plan
- Single app 0 write, addr 0x100, mem_req_grant_in=1 → grant_out[0] in cycle N, mem_req_out valid with addr 0x100 in N+1, idle in N+2.
- Apps 0–3 all valid continuously, memory always granting → grant sequence 0,1,2,3,0,... with one request per cycle.
- mem_req_grant_in=0 for 5 cycles with HR valid → no app grants, mem_req_out stable for 5 cycles, released on the grant edge.
- MAX_OUTSTANDING=2, app 1 issues 3 reads with no responses → third read not granted and app 2 still served. After one rsp_app_in=1, the third read is granted.
- Same-cycle read grant and response for app 0 with outst=1 → outst stays 1. A response for app 3 with outst=0 → cnt_underflow_out=1, held until reset.
- With AMI_CHAN_ARB_STATS_EN, 10 grants to app 2 → stat_grants_out[2]=10. Assert rst mid-stream → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ami_channel_app_arbiter_pkg.sv
// rtl/ami_channel_app_arbiter_pkg.sv - AMI request type and channel arbiter defaults
package ami_channel_app_arbiter_pkg;

    // Wide enough to name any of up to 8 apps.
    localparam int AMI_APP_BITS = 3;

    localparam int AMI_CHAN_ARB_NUM_APPS        = 4;
    localparam int AMI_CHAN_ARB_MAX_OUTSTANDING = 16;

    typedef struct packed {
        logic                    valid;
        logic                    isWrite;
        logic [AMI_APP_BITS-1:0] srcApp;
        logic [63:0]             addr;
        logic [31:0]             size;
    } AMIReq;

endpackage

// File: rtl/ami_outst_counter.sv
// rtl/ami_outst_counter.sv - per-app outstanding read counter with underflow pulse
module ami_outst_counter
    import ami_channel_app_arbiter_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    // A simultaneous issue and return cancel out; a return at zero leaves the count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Pulses when a return arrives with nothing in flight for this app.
    always_comb begin
        underflow = dec && !inc && (count == '0);
    end

endmodule

// File: rtl/rrwc_arbiter.sv
// rtl/rrwc_arbiter.sv - round-robin one-hot selector starting at a supplied pointer
module RRWCArbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!grant_any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ami_channel_app_arbiter.sv
// rtl/ami_channel_app_arbiter.sv - per-channel round-robin app arbiter with read caps; AMI_CHAN_ARB_STATS_EN adds grant counters
module ami_channel_app_arbiter
    import ami_channel_app_arbiter_pkg::*;
#(
    parameter int NUM_APPS        = AMI_CHAN_ARB_NUM_APPS,
    parameter int MAX_OUTSTANDING = AMI_CHAN_ARB_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  AMIReq                   app_req_in [NUM_APPS],
    output logic [NUM_APPS-1:0]     app_req_grant_out,
    output AMIReq                   mem_req_out,
    input  logic                    mem_req_grant_in,
    input  logic                    rsp_valid_in,
    input  logic [AMI_APP_BITS-1:0] rsp_app_in,
    output logic                    cnt_underflow_out,
    output logic [31:0]             stat_grants_out [NUM_APPS]
);

    localparam int IDX_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;

    AMIReq               hr;
    AMIReq               win_req;
    logic [IDX_W-1:0]    ptr;
    logic [NUM_APPS-1:0] eligible;
    logic [NUM_APPS-1:0] req_vec;
    logic [NUM_APPS-1:0] grant_vec;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                can_accept;
    logic [NUM_APPS-1:0] cnt_inc;
    logic [NUM_APPS-1:0] cnt_dec;
    logic [NUM_APPS-1:0] uf_pulse;
    logic [CNT_W-1:0]    outst [NUM_APPS];

    // The holding register frees up when empty or when memory takes its entry this cycle.
    always_comb begin
        can_accept = !hr.valid || mem_req_grant_in;
    end

    // Writes are never capped; reads only while the app is below its in-flight limit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            eligible[i] = app_req_in[i].valid &&
                          (app_req_in[i].isWrite || (outst[i] < CNT_W'(MAX_OUTSTANDING)));
        end
        req_vec = (can_accept && !rst) ? eligible : '0;
    end

    RRWCArbiter #(
        .N     (NUM_APPS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_vec),
        .ptr       (ptr),
        .grant     (grant_vec),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign app_req_grant_out = grant_vec;
    assign mem_req_out       = hr;

    // The winning request is tagged with the app it came from.
    always_comb begin
        win_req        = app_req_in[grant_idx];
        win_req.srcApp = AMI_APP_BITS'(grant_idx);
    end

    // Load on a grant, drop when memory drains it, otherwise hold stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr <= '0;
        end else if (grant_any) begin
            hr <= win_req;
        end else if (mem_req_grant_in) begin
            hr.valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDX_W'(NUM_APPS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_APPS; gi++) begin : g_outst
            assign cnt_inc[gi] = grant_vec[gi] && !app_req_in[gi].isWrite;
            assign cnt_dec[gi] = rsp_valid_in && (rsp_app_in == AMI_APP_BITS'(gi));

            ami_outst_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (cnt_inc[gi]),
                .dec       (cnt_dec[gi]),
                .count     (outst[gi]),
                .underflow (uf_pulse[gi])
            );
        end
    endgenerate

    // Underflow is sticky until reset so software can spot a lost or duplicated response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_underflow_out <= 1'b0;
        end else if (|uf_pulse) begin
            cnt_underflow_out <= 1'b1;
        end
    end

`ifdef AMI_CHAN_ARB_STATS_EN
    logic [31:0] stat_q [NUM_APPS];

    // Per-app grant counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_APPS; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_APPS; i++) begin
                if (grant_vec[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_APPS; gi++) begin : g_stat
            assign stat_grants_out[gi] = stat_q[gi];
        end
    endgenerate
`else
    generate
        for (gi = 0; gi < NUM_APPS; gi++) begin : g_stat
            assign stat_grants_out[gi] = 32'd0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ami_channel_app_arbiter.sv
// tb/tb_ami_channel_app_arbiter.sv - directed and randomized checks of ami_channel_app_arbiter
module tb_ami_channel_app_arbiter;
    import ami_channel_app_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst;
    AMIReq        req [N];
    logic [N-1:0] gnt;
    AMIReq        mem;
    logic         mem_gnt;
    logic         rsp_v;
    logic [2:0]   rsp_app;
    logic         uf;
    logic [31:0]  stat [N];

    int checks = 0;
    int errors = 0;

    AMIReq       m_hr;
    int          m_ptr;
    int          m_outst [N];
    bit          m_uf;
    logic [31:0] m_stat [N];
    int          last_k;

    always #5 clk = ~clk;

    ami_channel_app_arbiter #(
        .NUM_APPS        (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .app_req_in        (req),
        .app_req_grant_out (gnt),
        .mem_req_out       (mem),
        .mem_req_grant_in  (mem_gnt),
        .rsp_valid_in      (rsp_v),
        .rsp_app_in        (rsp_app),
        .cnt_underflow_out (uf),
        .stat_grants_out   (stat)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) req[i] = '0;
        mem_gnt = 1'b0;
        rsp_v   = 1'b0;
        rsp_app = '0;
    endtask

    task automatic model_reset();
        m_hr  = '0;
        m_ptr = 0;
        m_uf  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_outst[i] = 0;
            m_stat[i]  = '0;
        end
    endtask

    function automatic int model_pick();
        int k;
        k = -1;
        if (!m_hr.valid || mem_gnt) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (m_ptr + off) % N;
                if (k < 0 && req[i].valid && (req[i].isWrite || m_outst[i] < MAXO)) k = i;
            end
        end
        return k;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        int k;
        logic [N-1:0] exp_g;
        k = model_pick();
        exp_g = '0;
        if (k >= 0) exp_g[k] = 1'b1;
        last_k = k;
        #1;
        check("grant_vec", gnt, exp_g);
        if (k >= 0) begin
            m_hr        = req[k];
            m_hr.srcApp = 3'(k);
            m_ptr       = (k + 1) % N;
            if (m_stat[k] != 32'hFFFF_FFFF) m_stat[k] = m_stat[k] + 1;
        end else if (mem_gnt) begin
            m_hr.valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            bit inc, dec;
            inc = (k == i) && !req[i].isWrite;
            dec = rsp_v && (int'(rsp_app) == i);
            if (inc && !dec) m_outst[i]++;
            else if (dec && !inc) begin
                if (m_outst[i] == 0) m_uf = 1'b1;
                else m_outst[i]--;
            end
        end
        @(posedge clk);
        #1;
        check("mem_valid", mem.valid, m_hr.valid);
        if (m_hr.valid) check("mem_req", mem, m_hr);
        check("underflow", uf, m_uf);
        for (int i = 0; i < N; i++) begin
`ifdef AMI_CHAN_ARB_STATS_EN
            check("stat_grants", stat[i], m_stat[i]);
`else
            check("stat_tied0", stat[i], 32'd0);
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        int prev, n1, n0;
        AMIReq held;

        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mem_valid", mem.valid, 1'b0);
        check("reset_grants", gnt, 4'b0);
        check("reset_underflow", uf, 1'b0);
        check("reset_stat2", stat[2], 32'd0);
        @(negedge clk);

        // Single write from app 0; srcApp field must be overwritten with 0.
        req[0] = '{valid: 1'b1, isWrite: 1'b1, srcApp: 3'd3, addr: 64'h100, size: 32'd8};
        mem_gnt = 1'b1;
        cycle();
        check("single_grant_app", last_k, 0);
        check("single_addr_n1", mem.addr, 64'h100);
        check("single_src_n1", mem.srcApp, 3'd0);
        clear_inputs();
        mem_gnt = 1'b1;
        cycle();
        check("single_idle_n2", mem.valid, 1'b0);

        // All four apps writing, memory always ready: strict rotation, one per cycle.
        for (int i = 0; i < N; i++)
            req[i] = '{valid: 1'b1, isWrite: 1'b1, srcApp: 3'd0, addr: 64'(32'h1000 + i), size: 32'd4};
        mem_gnt = 1'b1;
        prev = -1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            check("rr_every_cycle", last_k >= 0, 1'b1);
            if (prev >= 0) check("rr_order", last_k, (prev + 1) % N);
            prev = last_k;
        end

        // Back-pressure for 5 cycles: no grants, held entry stable.
        mem_gnt = 1'b0;
        held = mem;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("bp_no_grant", last_k, -1);
            check("bp_stable", mem, held);
        end
        mem_gnt = 1'b1;
        cycle();
        check("bp_release", last_k >= 0, 1'b1);

        // Out-of-range response id is ignored.
        clear_inputs();
        mem_gnt = 1'b1;
        rsp_v = 1'b1;
        rsp_app = 3'd6;
        cycle();
        check("oor_rsp_no_uf", uf, 1'b0);
        rsp_v = 1'b0;

        // Read cap: app 1 reads stall at 2 in flight while app 2 writes keep flowing.
        req[1] = '{valid: 1'b1, isWrite: 1'b0, srcApp: 3'd0, addr: 64'h2000, size: 32'd64};
        req[2] = '{valid: 1'b1, isWrite: 1'b1, srcApp: 3'd0, addr: 64'h3000, size: 32'd64};
        n1 = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_k == 1) n1++;
        end
        check("cap_app1_reads", n1, 2);
        rsp_v = 1'b1;
        rsp_app = 3'd1;
        cycle();
        check("cap_rsp_cycle_app2", last_k, 2);
        rsp_v = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            if (last_k == 1) n1++;
        end
        check("cap_third_read", n1, 3);
        clear_inputs();
        mem_gnt = 1'b1;
        rsp_v = 1'b1;
        rsp_app = 3'd1;
        repeat (2) cycle();

        // Same-cycle issue and return for app 0 leaves its count at 1.
        clear_inputs();
        mem_gnt = 1'b1;
        req[0] = '{valid: 1'b1, isWrite: 1'b0, srcApp: 3'd0, addr: 64'h40, size: 32'd16};
        cycle();
        rsp_v = 1'b1;
        rsp_app = 3'd0;
        cycle();
        check("same_cycle_grant", last_k, 0);
        rsp_v = 1'b0;
        n0 = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (last_k == 0) n0++;
        end
        check("same_cycle_count_kept", n0, 1);
        clear_inputs();
        mem_gnt = 1'b1;
        rsp_v = 1'b1;
        rsp_app = 3'd0;
        repeat (2) cycle();
        check("drained_no_uf", uf, 1'b0);

        // Response for app 3 with nothing in flight: sticky underflow.
        rsp_app = 3'd3;
        cycle();
        check("underflow_set", uf, 1'b1);
        rsp_v = 1'b0;
        repeat (3) cycle();
        check("underflow_sticky", uf, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i].valid   = ($urandom_range(0, 1) == 1);
                req[i].isWrite = ($urandom_range(0, 1) == 1);
                req[i].srcApp  = 3'($urandom_range(0, 7));
                req[i].addr    = {32'($urandom), 32'($urandom)};
                req[i].size    = 32'($urandom);
            end
            mem_gnt = ($urandom_range(0, 3) != 0);
            rsp_v   = ($urandom_range(0, 9) < 3);
            rsp_app = 3'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset while an entry is held.
        clear_inputs();
        for (int i = 0; i < N; i++)
            req[i] = '{valid: 1'b1, isWrite: 1'b1, srcApp: 3'd0, addr: 64'h5000, size: 32'd1};
        mem_gnt = 1'b1;
        cycle();
        mem_gnt = 1'b0;
        cycle();
        check("pre_reset_held", mem.valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mem_valid", mem.valid, 1'b0);
        check("async_rst_grants", gnt, 4'b0);
        check("async_rst_underflow", uf, 1'b0);
        check("async_rst_stat0", stat[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        model_reset();
        cycle();
        req[0] = '{valid: 1'b1, isWrite: 1'b0, srcApp: 3'd0, addr: 64'h77, size: 32'd2};
        mem_gnt = 1'b1;
        cycle();
        check("post_reset_ptr0", last_k, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
